// File: rtl/vga_pkg.sv
// Default 640x480 @ 60 Hz raster timing and helpers that derive totals and sync
// positions from the visible/porch/sync widths.
package vga_pkg;

    localparam int unsigned DEF_CLK_DIV   = 2;
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    function automatic int unsigned total_of(input int unsigned vis, fp, sync, bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_start_of(input int unsigned vis, fp);
        return vis + fp;
    endfunction

    function automatic int unsigned sync_end_of(input int unsigned vis, fp, sync);
        return vis + fp + sync - 1;
    endfunction

    localparam int unsigned H_TOTAL  = total_of(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned V_TOTAL  = total_of(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int unsigned HS_START = sync_start_of(DEF_H_VISIBLE, DEF_H_FP);
    localparam int unsigned HS_END   = sync_end_of(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC);
    localparam int unsigned VS_START = sync_start_of(DEF_V_VISIBLE, DEF_V_FP);
    localparam int unsigned VS_END   = sync_end_of(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/sync_counter.sv
// One raster axis: wrapping position counter with combinational sync/visible decode
// of the current (pre-advance) count.
module sync_counter import vga_pkg::*; #(
    parameter int unsigned VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned FP      = DEF_H_FP,
    parameter int unsigned SYNC    = DEF_H_SYNC,
    parameter int unsigned BP      = DEF_H_BP
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       en,
    output logic [9:0] count,
    output logic       wrap,
    output logic       sync_n,
    output logic       visible
);

    localparam logic [9:0] LAST     = 10'(total_of(VISIBLE, FP, SYNC, BP) - 1);
    localparam logic [9:0] S_START  = 10'(sync_start_of(VISIBLE, FP));
    localparam logic [9:0] S_END    = 10'(sync_end_of(VISIBLE, FP, SYNC));
    localparam logic [9:0] VIS_LAST = 10'(VISIBLE);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 10'd1;
        end
    end

    assign wrap    = (count == LAST);
    assign sync_n  = !((count >= S_START) && (count <= S_END));
    assign visible = (count < VIS_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-clock divider, H/V counters feeding color_mapper, and a
// pixel_ce-registered output stage that keeps sync, blank and colour one pixel behind.
module vga_timing_gen import vga_pkg::*; #(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pixel_ce,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_start
);

    localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             h_wrap, h_sync_n, h_vis;
    logic             v_wrap, v_sync_n, v_vis;
    logic             v_en, vis;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            div <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
    end

    // Gated by Reset so the strobe is low during reset even when CLK_DIV is 1.
    assign pixel_ce = !Reset && (div == DIV_LAST);
    assign v_en     = pixel_ce && h_wrap;

    sync_counter #(
        .VISIBLE(H_VISIBLE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk    (clk),
        .Reset  (Reset),
        .en     (pixel_ce),
        .count  (DrawX),
        .wrap   (h_wrap),
        .sync_n (h_sync_n),
        .visible(h_vis)
    );

    sync_counter #(
        .VISIBLE(V_VISIBLE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk    (clk),
        .Reset  (Reset),
        .en     (v_en),
        .count  (DrawY),
        .wrap   (v_wrap),
        .sync_n (v_sync_n),
        .visible(v_vis)
    );

    assign vis = h_vis && v_vis;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pixel_ce) begin
            VGA_HS      <= h_sync_n;
            VGA_VS      <= v_sync_n;
            VGA_BLANK_N <= vis;
            VGA_R       <= vis ? Red   : 8'h00;
            VGA_G       <= vis ? Green : 8'h00;
            VGA_B       <= vis ? Blue  : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_ce && h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations share one clock; each has a per-cycle
// scoreboard plus directed measurements of sync, blank, frame_start and reset behaviour.
module tb_vga_timing_gen;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Config 0: default timing, CLK_DIV 2. Config 1: default timing, CLK_DIV 4.
    // Config 2: shrunken raster, CLK_DIV 2, so whole frames fit in a short run.
    function automatic int cfg_cd(input int g);  return (g == 1) ? 4 : 2;    endfunction
    function automatic int cfg_hv(input int g);  return (g == 2) ? 16 : 640; endfunction
    function automatic int cfg_hf(input int g);  return (g == 2) ? 4 : 16;   endfunction
    function automatic int cfg_hs(input int g);  return (g == 2) ? 6 : 96;   endfunction
    function automatic int cfg_hb(input int g);  return (g == 2) ? 4 : 48;   endfunction
    function automatic int cfg_vv(input int g);  return (g == 2) ? 12 : 480; endfunction
    function automatic int cfg_vf(input int g);  return (g == 2) ? 2 : 10;   endfunction
    function automatic int cfg_vs(input int g);  return 2;                   endfunction
    function automatic int cfg_vb(input int g);  return (g == 2) ? 3 : 33;   endfunction
    function automatic logic [23:0] cfg_col(input int g);
        return (g == 1) ? 24'h3CA57E : 24'hFF8001;
    endfunction

    // Expected {pixel_ce, DrawX, DrawY, HS, VS, BLANK_N, frame_start, R, G, B} after
    // t clock edges out of reset, derived from absolute pixel counts.
    function automatic logic [48:0] model(input int t, input int cd, input int hv, input int hf,
                                          input int hsy, input int hb, input int vv,
                                          input int vf, input int vsy, input int vb,
                                          input logic [23:0] col);
        int ht, vt, k, q, qh, qv, hc, vc;
        logic ce, vis, hs, vs, fs;
        logic [23:0] rgb;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        k  = t / cd;
        ce = ((t % cd) == cd - 1);
        hc = k % ht;
        vc = (k / ht) % vt;
        if (k == 0) begin
            vis = 1'b0; hs = 1'b1; vs = 1'b1; fs = 1'b0; rgb = '0;
        end else begin
            q   = k - 1;
            qh  = q % ht;
            qv  = (q / ht) % vt;
            vis = (qh < hv) && (qv < vv);
            hs  = !((qh >= hv + hf) && (qh < hv + hf + hsy));
            vs  = !((qv >= vv + vf) && (qv < vv + vf + vsy));
            rgb = vis ? col : 24'h0;
            fs  = ((t % cd) == 0) && ((k % (ht * vt)) == 0);
        end
        return {ce, 10'(hc), 10'(vc), hs, vs, vis, fs, rgb};
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int CD  = cfg_cd(g);
        localparam int HV  = cfg_hv(g);
        localparam int HF  = cfg_hf(g);
        localparam int HSY = cfg_hs(g);
        localparam int HB  = cfg_hb(g);
        localparam int VV  = cfg_vv(g);
        localparam int VF  = cfg_vf(g);
        localparam int VSY = cfg_vs(g);
        localparam int VB  = cfg_vb(g);
        localparam int HT  = HV + HF + HSY + HB;
        localparam int VT  = VV + VF + VSY + VB;
        localparam int FT  = HT * VT;
        localparam logic [23:0] COL = cfg_col(g);
        localparam int RUN1 = (g == 2) ? (2 * FT * CD + 9 * HT * CD + 7) : (2 * HT * CD + 700);
        localparam int RUN2 = (g == 2) ? (FT * CD + 200) : (HT * CD + 200);

        logic       rst = 1'b1;
        logic [7:0] red, grn, blu;
        logic [9:0] dx, dy;
        logic       pce, hs, vs, bn, fs;
        logic [7:0] vr, vg, vb;
        bit         done = 1'b0;
        logic [48:0] sb_q[$];

        vga_timing_gen #(
            .CLK_DIV  (CD),
            .H_VISIBLE(HV),
            .H_FP     (HF),
            .H_SYNC   (HSY),
            .H_BP     (HB),
            .V_VISIBLE(VV),
            .V_FP     (VF),
            .V_SYNC   (VSY),
            .V_BP     (VB)
        ) u_dut (
            .clk        (clk),
            .Reset      (rst),
            .Red        (red),
            .Green      (grn),
            .Blue       (blu),
            .DrawX      (dx),
            .DrawY      (dy),
            .pixel_ce   (pce),
            .VGA_HS     (hs),
            .VGA_VS     (vs),
            .VGA_BLANK_N(bn),
            .VGA_R      (vr),
            .VGA_G      (vg),
            .VGA_B      (vb),
            .frame_start(fs)
        );

        // Producer: advance the model on every edge and queue the expected outputs.
        initial begin : producer
            int t;
            t = 0;
            forever begin
                @(posedge clk);
                if (rst) t = 0;
                else t = t + 1;
                sb_q.push_back(model(t, CD, HV, HF, HSY, HB, VV, VF, VSY, VB, COL));
            end
        end

        // Monitor: compare the presented outputs half a cycle later.
        initial begin : monitor
            logic [48:0] exp;
            forever begin
                @(negedge clk);
                if (sb_q.size() > 0) begin
                    exp = sb_q.pop_front();
                    check($sformatf("g%0d_cycle", g),
                          64'({pce, dx, dy, hs, vs, bn, fs, vr, vg, vb}), 64'(exp));
                end
            end
        end

        // Directed measurements of run lengths and edge positions.
        initial begin : meas
            int hs_low, bn_hi, vs_low, since;
            logic hs_p, bn_p, vs_p;
            hs_low = 0; bn_hi = 0; vs_low = 0; since = 0;
            hs_p = 1'b1; bn_p = 1'b0; vs_p = 1'b1;
            forever begin
                @(negedge clk);
                if (rst) begin
                    hs_low = 0; bn_hi = 0; vs_low = 0; since = 0;
                    hs_p = 1'b1; bn_p = 1'b0; vs_p = 1'b1;
                end else begin
                    since++;
                    if (hs_p && !hs) check($sformatf("g%0d_hs_fall_x", g), 64'(dx), 64'(HV + HF + 1));
                    if (!hs_p && hs) begin
                        check($sformatf("g%0d_hs_low_clks", g), 64'(hs_low), 64'(HSY * CD));
                        check($sformatf("g%0d_hs_rise_x", g), 64'(dx), 64'(HV + HF + HSY + 1));
                    end
                    if (bn_p && !bn) check($sformatf("g%0d_blank_hi_clks", g), 64'(bn_hi), 64'(HV * CD));
                    if (vs_p && !vs) check($sformatf("g%0d_vs_fall_xy", g), 64'({dx, dy}),
                                           64'({10'd1, 10'(VV + VF)}));
                    if (!vs_p && vs) check($sformatf("g%0d_vs_low_clks", g), 64'(vs_low),
                                           64'(VSY * HT * CD));
                    if (fs) begin
                        check($sformatf("g%0d_fs_interval", g), 64'(since), 64'(FT * CD));
                        since = 0;
                    end
                    hs_low = hs ? 0 : hs_low + 1;
                    bn_hi  = bn ? bn_hi + 1 : 0;
                    vs_low = vs ? 0 : vs_low + 1;
                    hs_p = hs; bn_p = bn; vs_p = vs;
                end
            end
        end

        initial begin : stim
            int  edges;
            bit  found;
            {red, grn, blu} = COL;
            rst = 1'b1;
            repeat (5) @(posedge clk);
            @(negedge clk);
            check($sformatf("g%0d_rst_xy", g), 64'({dx, dy}), 64'(0));
            check($sformatf("g%0d_rst_sync", g), 64'({pce, hs, vs, bn, fs}), 64'(5'b01100));
            check($sformatf("g%0d_rst_rgb", g), 64'({vr, vg, vb}), 64'(0));
            #2 rst = 1'b0;

            edges = 0;
            found = 1'b0;
            for (int i = 0; i < 4 * CD && !found; i++) begin
                @(posedge clk);
                edges++;
                #1 if (dx == 10'd1) found = 1'b1;
            end
            check($sformatf("g%0d_first_px_edge", g), 64'(edges), 64'(CD));

            repeat (RUN1) @(posedge clk);
            // Assert reset between edges and look before the next edge arrives.
            @(negedge clk);
            #2 rst = 1'b1;
            #1;
            check($sformatf("g%0d_async_xy", g), 64'({dx, dy}), 64'(0));
            check($sformatf("g%0d_async_sync", g), 64'({pce, hs, vs, bn, fs}), 64'(5'b01100));
            check($sformatf("g%0d_async_rgb", g), 64'({vr, vg, vb}), 64'(0));
            repeat (3) @(posedge clk);
            @(negedge clk);
            #2 rst = 1'b0;
            repeat (RUN2) @(posedge clk);
            done = 1'b1;
        end
    end

    initial begin : summary
        bit all_done;
        all_done = 1'b0;
        for (int i = 0; i < 60000 && !all_done; i++) begin
            @(posedge clk);
            all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done;
        end
        check("run_complete", 64'(all_done), 64'(1));
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz raster for the ball/sprite display path. It divides the system clock down to a pixel-clock enable and drives `DrawX`/`DrawY` into `color_mapper`. It then takes back the `Red`/`Green`/`Blue` that `color_mapper` returns for that pixel, registers them, and emits them to the DAC together with aligned sync and blank signals. It is the scan-side counterpart of `color_mapper`, which consumes coordinates and produces colour.

## Interface
Parameters:
- `CLK_DIV`, 2, system clocks per pixel; pixel_ce period.
- `H_VISIBLE`, 640, visible pixels per line.
- `H_FP`, 16, horizontal front porch.
- `H_SYNC`, 96, horizontal sync width.
- `H_BP`, 48, horizontal back porch.
- `V_VISIBLE`, 480, visible lines per frame.
- `V_FP`, 10, vertical front porch.
- `V_SYNC`, 2, vertical sync width.
- `V_BP`, 33, vertical back porch.

Ports:
- `clk`, in, 1, system clock. One clock domain; all state is on its rising edge.
- `Reset`, in, 1, asynchronous, active-high reset.
- `Red`, `Green`, `Blue`, in, 8 each, colour from `color_mapper` for the current `DrawX`/`DrawY`.
- `DrawX`, out, 10, current horizontal count, 0..799.
- `DrawY`, out, 10, current vertical count, 0..524.
- `pixel_ce`, out, 1, one-clk pulse per pixel.
- `VGA_HS`, out, 1, horizontal sync, active low.
- `VGA_VS`, out, 1, vertical sync, active low.
- `VGA_BLANK_N`, out, 1, high while the pixel is visible.
- `VGA_R`, `VGA_G`, `VGA_B`, out, 8 each, registered colour to the DAC.
- `frame_start`, out, 1, one-clk pulse at the start of each frame.

## Operation
Divider:
- Counter `div` runs 0..CLK_DIV-1 and wraps.
- `pixel_ce` is 1 exactly when `div == CLK_DIV-1`.

Horizontal counter `hc` (= `DrawX`):
- Advances on `pixel_ce`.
- Wraps from H_TOTAL-1 (799) to 0.
- The wrap asserts `line_end`.

Vertical counter `vc` (= `DrawY`):
- Advances when `pixel_ce && line_end`.
- Wraps from V_TOTAL-1 (524) to 0.

Counter ranges:
- `DrawX`/`DrawY` cover the full 0..799 / 0..524 range, including blanking.
- `color_mapper` output outside the visible area is ignored.

Output stage, registered on `pixel_ce`, computed from the pre-advance `hc`/`vc`:
- `vis = hc < 640 && vc < 480`.
- `VGA_BLANK_N <= vis`.
- `VGA_HS <= !(656 <= hc <= 751)`.
- `VGA_VS <= !(490 <= vc <= 491)`.
- `VGA_R/G/B <= vis ? Red/Green/Blue : 0`.

`frame_start`:
- Registered.
- High for the one clk following the `pixel_ce` on which `(hc,vc)` wraps from (799,524) to (0,0).

Width rules:
- Sync/porch bounds are derived: HS from H_VISIBLE+H_FP to H_VISIBLE+H_FP+H_SYNC-1; VS likewise.
- Comparisons are unsigned 10-bit.

## Timing
Reset values while `Reset` is high:
- `div`, `hc`, `vc` = 0.
- `pixel_ce` = 0, `frame_start` = 0.
- `VGA_HS` = 1, `VGA_VS` = 1.
- `VGA_BLANK_N` = 0.
- `VGA_R/G/B` = 0.

After reset release:
- The first `pixel_ce` occurs in the CLK_DIV-th clk (clk 2 for CLK_DIV=2).
- Reset asserted mid-frame returns everything to the reset values immediately, asynchronously.
- Counting restarts from (0,0). No partial-frame `frame_start` is issued.

Pipeline alignment:
- Outputs lag `DrawX`/`DrawY` by exactly one pixel (CLK_DIV clks).
- `color_mapper` is combinational; `Red`/`Green`/`Blue` must settle within one pixel period.
- Sync, blank and colour are all registered by the same `pixel_ce`, so they stay mutually aligned.

Period lengths:
- Line = 800 pixels = 1600 clks.
- Frame = 525 lines = 840000 clks.

Simultaneous events:
- Line wrap and frame wrap on the same `pixel_ce` update `hc` and `vc` together.
- `pixel_ce` is never skipped.

## Structure
- Package `vga_pkg` holds:
  - the default timing localparams;
  - derived `H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP` and `V_TOTAL`;
  - the HS/VS start and end constants.
- Sub-module `sync_counter` is parameterized by VISIBLE/FP/SYNC/BP.
  - Inputs: `clk`, `Reset`, `en`.
  - Outputs: `count`, `wrap`, `sync_n`, `visible`.
- `sync_counter` is instantiated twice:
  - horizontal, with `en = pixel_ce`;
  - vertical, with `en = pixel_ce && h.wrap`.
- The top level holds the divider, the output register stage and `frame_start`.

## Test plan
- **Reset:** hold `Reset` for 5 clks, then release → all outputs at their reset values during reset; first `pixel_ce` at clk 2 after release; `DrawX` = 1 after it.
- **Hsync:** run to `DrawX` = 656 → `VGA_HS` falls on the following `pixel_ce`, stays low for 96 pixels (192 clks), and rises when the registered `hc` reaches 752.
- **Blanking:** drive `Red/Green/Blue` = 8'hFF/8'h80/8'h01 constant → `VGA_R/G/B` = FF/80/01 with `VGA_BLANK_N` = 1 for 640 pixels per visible line, 0 during H blank and in lines 480..524.
- **Frame wrap:** run 840000 clks → exactly one `frame_start` pulse; `DrawX`/`DrawY` = 0/0; `VGA_VS` low for exactly 2 lines (3200 clks) beginning at line 490 + one pixel.
- **Mid-frame reset:** assert `Reset` asynchronously, between clk edges, at `DrawY` = 200 → all outputs take their reset values without waiting for a clock edge; no `frame_start`; after release, the raster restarts at (0,0) and the next `frame_start` comes 840000 clks later.
- **CLK_DIV = 4:** → `pixel_ce` every 4 clks; line = 3200 clks; same pixel-level sync positions as the CLK_DIV = 2 run.
